uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; mirror of the team's uart_tx (same frame format, same CLKS_PER_BIT default, 100 MHz / 9600 baud).
- Accepts the asynchronous serial line from the RsRx pin and synchronises it.
- Detects and validates the start bit, samples 8 data bits LSB-first at mid-bit, checks the stop bit.
- Delivers the byte with a one-cycle valid strobe to the AES command/data front end.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit (100 MHz / 9600 baud); must be >= 8.
- CNT_W, 14, clk_count width; must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- rx_serial  in  1  raw serial line (RsRx pin), idles high, asynchronous to clk.
- rx_data  out  8  last correctly framed byte; held until the next good frame.
- rx_valid  out  1  one-cycle pulse: rx_data updated with a good byte.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low; byte discarded.
- rx_busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset values (async, rst_n low):
  - rx_data=0, rx_valid=0, rx_frame_err=0, rx_busy=0.
  - state=IDLE, clk_count=0, bit_index=0.
  - Synchroniser flops=1 (line idle).
- Reset mid-frame aborts immediately. No partial byte is delivered.
- Synchroniser:
  - rx_serial passes through 2 flops giving rx_s, plus one history flop rx_d.
  - Falling edge = rx_d==1 && rx_s==0.
- States: IDLE, START, DATA, STOP, CLEANUP. Encodings live in the package. Any other encoding goes to IDLE.
- IDLE:
  - rx_busy=0, clk_count=0, bit_index=0.
  - Falling edge -> START, rx_busy=1.
  - A line held low (break) causes no retrigger until a high is seen.
- START:
  - Count to (CLKS_PER_BIT-1)/2 (integer division), then sample rx_s.
  - Sample 0 -> DATA, clk_count=0.
  - Sample 1 -> glitch; back to IDLE, no outputs pulsed.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift_reg[bit_index] and reset clk_count.
  - bit_index 0..7 increments. After bit 7 -> STOP, bit_index=0.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample.
  - Sample 1: rx_data<=shift_reg, rx_valid=1 for one cycle.
  - Sample 0: rx_frame_err=1 for one cycle, rx_data unchanged.
  - Either way -> CLEANUP.
- CLEANUP: one cycle, rx_busy<=0, -> IDLE.
  - The remaining half stop bit is spent in IDLE, so a back-to-back frame (next start edge one bit after the stop-bit start) is received.
- Latency:
  - rx_valid rises 3 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT (+/-2) cycles after the rx_serial falling edge at the pin.
  - rx_valid and rx_frame_err are never high together.
- No FIFO and no backpressure. The consumer must capture rx_data within one frame time.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every sample point (start, data, stop) takes rx_s at count-1, count, count+1 and uses the 2-of-3 majority.
  - The decision is made at count+1, so all sample points shift one cycle later.
  - Single-cycle glitches at the sample point are rejected.
- Undefined: single sample at the nominal point as above, with no extra flops.

Decomposition:
- Package uart_pkg holds:
  - state localparams IDLE/START/DATA/STOP/CLEANUP (3-bit),
  - default CLKS_PER_BIT=10416,
  - DATA_BITS=8.
- The package is shared with uart_tx.
- One sub-module: uart_sync, a parameterised N-stage (default 2) synchroniser with reset value 1.

Test Plan (CLKS_PER_BIT=16):
- Send 0xA5 as a clean 8N1 frame -> exactly one rx_valid pulse, rx_data=0xA5, rx_frame_err stays 0, rx_busy low afterwards.
- Send 0x3C then 0xFF back-to-back with a single stop bit -> two rx_valid pulses, in order 0x3C then 0xFF.
- 4-cycle low glitch on an idle line -> returns to IDLE from START; no rx_valid, no rx_frame_err; rx_data unchanged.
- Frame 0x55 with stop bit forced low -> one rx_frame_err pulse, no rx_valid, rx_data keeps its previous value; line held low afterwards -> no further activity until it returns high.
- Assert rst_n low at DATA bit 4 of 0x81 -> all outputs 0 immediately; then send 0x81 again cleanly -> rx_data=0x81.
- With UART_RX_MAJORITY_EN defined: 1-cycle inverted glitch exactly at each data-bit mid-point of 0x96 -> rx_data=0x96, rx_valid pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   CLKS_PER_BIT_DEFAULT : clock cycles per bit (100 MHz / 9600 baud)
//   DATA_BITS            : data bits per frame (8N1)
//   BIT_IDX_W            : width of the data-bit index
//   uart_state_e         : 3-bit frame FSM states IDLE/START/DATA/STOP/CLEANUP
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 10416;
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned BIT_IDX_W            = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-stage flop synchroniser for a single asynchronous line.
// The stages reset to 1 so that an idle UART line does not produce a
// spurious falling edge when reset is released.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (STAGES cycles of latency)
module uart_sync
    import uart_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// Synchronises the RsRx line, detects a start bit on a falling edge,
// confirms it at mid-bit, samples 8 data bits LSB-first at mid-bit and
// checks the stop bit. A good frame updates rx_data with a one-cycle
// rx_valid pulse; a low stop bit gives a one-cycle rx_frame_err pulse and
// the byte is dropped.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   rx_serial    : raw serial line, idles high, asynchronous to clk
//   rx_data      : last correctly framed byte, held until the next good frame
//   rx_valid     : one-cycle pulse, rx_data updated
//   rx_frame_err : one-cycle pulse, stop bit sampled low
//   rx_busy      : high from start-bit detection until back in IDLE
// Build option UART_RX_MAJORITY_EN: each sample point takes the 2-of-3
// majority of rx_s at count-1, count, count+1, deciding one cycle later.
// CLKS_PER_BIT must be >= 8 and 2**CNT_W must exceed CLKS_PER_BIT.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned CNT_W        = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the nominal point, so the start
    // decision moves one cycle later; later bits keep the full bit period.
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2 + 1);
`else
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
`endif

    logic rx_s;
    logic rx_d_q;
    logic fall;
    logic sample_bit;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BIT_IDX_W-1:0] idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    uart_sync #(
        .STAGES (2)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_serial),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_d_q <= 1'b1;
        end else begin
            rx_d_q <= rx_s;
        end
    end

    // Needs a high before the low, so a held-low line never retriggers.
    assign fall = rx_d_q & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample_bit = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                count_d = '0;
                idx_d   = '0;
                if (fall) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (count_q == START_CNT) begin
                    count_d = '0;
                    if (!sample_bit) begin
                        state_d = DATA;
                    end else begin
                        // Line back high at mid start bit: a glitch, not a frame.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (count_q == FULL_CNT) begin
                    count_d         = '0;
                    shift_d[idx_q]  = sample_bit;
                    if (idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (count_q == FULL_CNT) begin
                    count_d = '0;
                    state_d = CLEANUP;
                    if (sample_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            CLEANUP: begin
                // Rest of the stop bit is spent in IDLE so a back-to-back
                // start edge is still caught.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                count_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_SHIFT = 1;
`else
    localparam int LAT_SHIFT = 0;
`endif
    localparam int LAT_NOM = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    // Event log written only by the monitor; the test reads it via ev_rd.
    typedef struct {
        logic       ferr;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t ev_log[$];
    int  cyc      = 0;
    int  busy_cnt = 0;
    int  both_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid === 1'b1)     ev_log.push_back('{1'b0, rx_data, cyc});
            if (rx_frame_err === 1'b1) ev_log.push_back('{1'b1, rx_data, cyc});
            if (rx_valid === 1'b1 && rx_frame_err === 1'b1) both_cnt++;
            if (rx_busy === 1'b1) busy_cnt++;
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         ev_rd  = 0;
    int         fall_cyc = 0;
    logic [7:0] last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_bit(input logic v, input bit glitch);
        for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            rx_serial = (glitch && j == CPB / 2) ? ~v : v;
        end
    endtask

    // Start bit, 8 data bits LSB first, then the given stop level (left on the line).
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
        @(negedge clk);
        rx_serial = 1'b0;
        fall_cyc  = cyc;
        repeat (CPB - 1) @(negedge clk);
        for (int k = 0; k < 8; k++) drive_bit(b[k], glitch);
        drive_bit(stop, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_serial = 1'b1;
        end
    endtask

    // Exactly one event expected since the last check: a valid with exp_byte,
    // or a frame error; rx_data must equal exp_data and busy must be low.
    task automatic check_frame(input string name, input bit exp_valid, input logic [7:0] exp_data);
        int  n;
        ev_t e;
        n = ev_log.size() - ev_rd;
        check({name, ".events"}, n, 1);
        if (n > 0) begin
            e = ev_log[ev_rd];
            check({name, ".kind_ferr"}, {31'd0, e.ferr}, {31'd0, !exp_valid});
            if (exp_valid) begin
                check({name, ".byte"}, {24'd0, e.data}, {24'd0, exp_data});
                check_range({name, ".latency"}, e.cyc - fall_cyc,
                            LAT_NOM - 2, LAT_NOM + 2 + LAT_SHIFT);
            end
        end
        ev_rd = ev_log.size();
        check({name, ".rx_data"}, {24'd0, rx_data}, {24'd0, exp_data});
        check({name, ".busy"}, {31'd0, rx_busy}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         gap;
        bit         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vec[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b0;
        logic [7:0] rb;
        logic       rstop;
        int         rgap;

        vec = '{
            '{8'hA5, 1'b1, 20, 1'b1, 8'hA5},
            '{8'h3C, 1'b1,  0, 1'b1, 8'h3C},   // back-to-back with next
            '{8'hFF, 1'b1, 20, 1'b1, 8'hFF},
            '{8'h55, 1'b0,  0, 1'b0, 8'hFF}    // bad stop, line left low
        };

        rst_n     = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.rx_data", {24'd0, rx_data}, 32'd0);
        check("reset.rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset.rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("reset.rx_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        idle(10);
        check("idle.no_events", ev_log.size(), 0);

        foreach (vec[i]) begin
            send_frame(vec[i].b, vec[i].stop, 1'b0);
            check_frame($sformatf("vec%0d", i), vec[i].exp_valid, vec[i].exp_data);
            if (vec[i].stop) idle(vec[i].gap);
        end
        last_data = 8'hFF;

        // Break: line stays low after the bad frame, nothing may start.
        b0 = busy_cnt;
        repeat (60) @(negedge clk);
        check("break.busy_cycles", busy_cnt - b0, 0);
        check("break.events", ev_log.size() - ev_rd, 0);
        idle(20);

        // 4-cycle low glitch on an idle line.
        b0 = busy_cnt;
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check_range("glitch.busy_cycles", busy_cnt - b0, 1, 2 * CPB);
        check("glitch.events", ev_log.size() - ev_rd, 0);
        check("glitch.rx_data", {24'd0, rx_data}, {24'd0, last_data});
        check("glitch.busy", {31'd0, rx_busy}, 32'd0);

        // Reset during data bit 4 of 0x81.
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int k = 0; k < 4; k++) drive_bit(k == 0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.rx_data", {24'd0, rx_data}, 32'd0);
        check("midreset.rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset.rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("midreset.rx_busy", {31'd0, rx_busy}, 32'd0);
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("midreset.no_events", ev_log.size() - ev_rd, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        last_data = 8'h81;
        check_frame("resend81", 1'b1, last_data);
        idle(5);

        // Random frames against a byte-level model.
        for (int k = 0; k < 24; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            rgap  = $urandom_range(0, 12);
            if (!rstop && rgap < 3) rgap = 3;
            send_frame(rb, rstop, 1'b0);
            if (rstop) last_data = rb;
            check_frame($sformatf("rand%0d", k), rstop, last_data);
            idle(rgap);
        end

`ifdef UART_RX_MAJORITY_EN
        idle(10);
        send_frame(8'h96, 1'b1, 1'b1);
        last_data = 8'h96;
        check_frame("majority96", 1'b1, last_data);
        idle(10);
`endif

        check("valid_and_err_together", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
